// File: rtl/chunked_add_seq.sv
// Multi-cycle adder: one CHUNK-bit ripple stage reused LSB-to-MSB, valid/ready on both sides.
// Optional signed-overflow output enabled by defining CHUNKED_ADD_SEQ_OVF_EN.
module chunked_add_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CHUNKED_ADD_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [N-1:0][CHUNK-1:0] a_q, b_q, sum_q;
    logic                    carry_q;
    logic                    cout_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CHUNK:0]          chunk_res;
    logic                    last;
    logic                    accept;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (idx_q == IDX_W'(N - 1));

    // The single shared adder stage; the extra MSB is the chunk carry-out.
    assign chunk_res = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand registers need no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= chunk_res[CHUNK-1:0];
                    carry_q      <= chunk_res[CHUNK];
                    idx_q        <= idx_q + IDX_W'(1);
                    if (last) cout_q <= chunk_res[CHUNK];
                end
                default: ;
            endcase
        end
    end

`ifdef CHUNKED_ADD_SEQ_OVF_EN
    logic ovf_q;
    logic msb_carry_in;

    // Carry into the top bit recovered from the sum bit: s = a ^ b ^ c_in.
    assign msb_carry_in = a_q[N-1][CHUNK-1] ^ b_q[N-1][CHUNK-1] ^ chunk_res[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= msb_carry_in ^ chunk_res[CHUNK];
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_add_seq.sv
// Directed self-checking bench for chunked_add_seq at WIDTH=8, CHUNK=2 (four cycles per add).
// Define CHUNKED_ADD_SEQ_OVF_EN to also exercise the overflow output.
module tb_chunked_add_seq;

    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CHUNKED_ADD_SEQ_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    chunked_add_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CHUNKED_ADD_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand set from IDLE and wait (bounded) for the result.
    task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc, input logic rdy);
        a         = va;
        b         = vb;
        cin       = vc;
        in_valid  = 1'b1;
        out_ready = rdy;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, N);
    endtask

    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] exp_sum, input logic exp_cout);
        start_op(va, vb, vc, 1'b1);
        wait_done(tag);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, cout, exp_cout);
        check({tag, "_in_ready_done"}, in_ready, 0);
        tick();
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_out_valid_after"}, out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 0);
`ifdef CHUNKED_ADD_SEQ_OVF_EN
        check("rst_ovf", ovf, 0);
`endif

        // 1: basic add with exact latency and handshake timing
        start_op(8'h0F, 8'h01, 1'b0, 1'b1);
        check("t1_busy_run", busy, 1);
        check("t1_in_ready_run", in_ready, 0);
        wait_done("t1");
        check("t1_sum", sum, 8'h10);
        check("t1_cout", cout, 0);
        check("t1_in_ready_done", in_ready, 0);
        tick();
        check("t1_in_ready_after", in_ready, 1);
        check("t1_busy_after", busy, 0);

        // 2: full carry ripple through every chunk
        run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("t2b", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

        // 3: backpressure holds the result; new operands are refused
        start_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        wait_done("t3");
        for (int i = 0; i < 3; i++) begin
            check("t3_sum_hold", sum, 8'h00);
            check("t3_cout_hold", cout, 1);
            check("t3_busy_hold", busy, 1);
            check("t3_in_ready_hold", in_ready, 0);
            check("t3_out_valid_hold", out_valid, 1);
            in_valid = (i == 1);
            a        = 8'h11;
            b        = 8'h11;
            tick();
        end
        in_valid  = 1'b0;
        check("t3_sum_after_pulse", sum, 8'h00);
        out_ready = 1'b1;
        tick();
        check("t3_idle_in_ready", in_ready, 1);
        check("t3_idle_busy", busy, 0);
        check("t3_sum_idle", sum, 8'h00);

        // 4: operand changes after accept must not disturb the result
        start_op(8'h12, 8'h34, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            n++;
        end
        check("t4_latency", n, N);
        check("t4_sum", sum, 8'h46);
        check("t4_cout", cout, 0);
        tick();

        // 5: reset on the second RUN cycle wins over in_valid/out_ready
        start_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        tick();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t5_in_ready", in_ready, 1);
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_sum", sum, 8'h00);
        check("t5_cout", cout, 0);
        for (int i = 0; i < N + 1; i++) begin
            tick();
            check("t5_no_out_valid", out_valid, 0);
        end
        run_op("t5b", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1);

`ifdef CHUNKED_ADD_SEQ_OVF_EN
        // 6: signed overflow flag
        run_op("t6a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        check("t6a_ovf_idle", ovf, 1);
        start_op(8'h80, 8'h80, 1'b0, 1'b1);
        check("t6b_ovf_cleared", ovf, 0);
        wait_done("t6b");
        check("t6b_sum", sum, 8'h00);
        check("t6b_cout", cout, 1);
        check("t6b_ovf", ovf, 1);
        tick();
        start_op(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done("t6c");
        check("t6c_sum", sum, 8'h30);
        check("t6c_ovf", ovf, 0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
